// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES wait
// states, performs the access on a byte-wide array and returns a registered response.
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U  = DEPTH;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                in_range;
  logic [IDX_W-1:0]    idx;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = (32'(addr_q) < DEPTH_U);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is high only in IDLE, resp_valid only in RESP, so they never overlap.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        if (in_range) begin
          mem_we  = write_q;
          rdata_d = write_q ? wdata_q : mem_q[idx];
          err_d   = 1'b0;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage is never reset; a reset on the ACCESS edge still blocks the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= wdata_q;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a DEPTH=128/WAIT_CYCLES=2 instance for latency,
// backpressure, range and reset checks, and a WAIT_CYCLES=0 instance for throughput.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int MAIN_WC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, resp_valid, resp_err;
  logic [7:0] resp_rdata;

  logic       t_req_valid = 1'b0, t_req_write = 1'b0, t_resp_ready = 1'b0;
  logic [7:0] t_req_addr = '0, t_req_wdata = '0;
  logic       t_req_ready, t_resp_valid, t_resp_err;
  logic [7:0] t_resp_rdata;

  logic [8:0] exp_q[$];
  int         tests_run = 0;
  int         tests_failed = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(MAIN_WC)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(t_req_write),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
    .resp_rdata(t_resp_rdata), .resp_err(t_resp_err)
  );

  // Drive one request until accepted; push its expected {err, data} on acceptance.
  task automatic send_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic e_err, input logic [7:0] e_dat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout addr=%h: req_ready=%b, required 1", a, req_ready);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({e_err, e_dat});
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom_range(0, 255));
    req_wdata = 8'($urandom_range(0, 255));
  endtask

  // Called at the negedge after the accept edge; checks latency, data and completion.
  task automatic recv_resp(input int hold);
    logic [8:0] exp_v;
    int n;
    for (int k = 1; k <= MAIN_WC + 1; k++) begin
      tests_run++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL resp_early k=%0d: resp_valid=%b req_ready=%b, required 0 0", k, resp_valid, req_ready);
      end
      @(negedge clk);
    end
    tests_run++;
    if (resp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL resp_latency: resp_valid=%b, required 1", resp_valid);
      n = 0;
      while (resp_valid !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL scoreboard_empty: response with no expectation");
      return;
    end
    exp_v = exp_q.pop_front();
    tests_run++;
    if ({resp_err, resp_rdata} !== exp_v) begin
      tests_failed++;
      $display("FAIL resp_data: err=%b rdata=%h, required err=%b rdata=%h", resp_err, resp_rdata, exp_v[8], exp_v[7:0]);
    end
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom_range(0, 255));
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || {resp_err, resp_rdata} !== exp_v) begin
        tests_failed++;
        $display("FAIL resp_hold h=%0d: valid=%b ready=%b err=%b rdata=%h, required 1 0 %b %h",
                 h, resp_valid, req_ready, resp_err, resp_rdata, exp_v[8], exp_v[7:0]);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL completion: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom_range(0, 1));
      req_addr   = 8'($urandom_range(0, 255));
      req_wdata  = 8'($urandom_range(0, 255));
      resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: %b, required 1", req_ready); end
    tests_run++;
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: %b, required 0", resp_valid); end
    tests_run++;
    if (resp_rdata !== 8'h00) begin tests_failed++; $display("FAIL reset_resp_rdata: %h, required 00", resp_rdata); end
    tests_run++;
    if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err: %b, required 0", resp_err); end
    tests_run++;
    if (t_req_ready !== 1'b1 || t_resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_dut0: req_ready=%b resp_valid=%b, required 1 0", t_req_ready, t_resp_valid);
    end
  endtask

  task automatic test_write_read();
    send_req(1'b1, 8'h10, 8'h3C, 1'b0, 8'h3C);
    recv_resp(0);
    send_req(1'b0, 8'h10, 8'h00, 1'b0, 8'h3C);
    recv_resp(0);
  endtask

  task automatic test_backpressure();
    send_req(1'b0, 8'h10, 8'h00, 1'b0, 8'h3C);
    recv_resp(5);
  endtask

  task automatic test_out_of_range();
    send_req(1'b1, 8'h80, 8'h55, 1'b1, 8'h00);
    recv_resp(0);
    send_req(1'b1, 8'h00, 8'hA7, 1'b0, 8'hA7);
    recv_resp(0);
    send_req(1'b0, 8'h00, 8'h00, 1'b0, 8'hA7);
    recv_resp(0);
    send_req(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00);
    recv_resp(0);
  endtask

  task automatic test_reset_mid();
    int n;
    send_req(1'b1, 8'h20, 8'h11, 1'b0, 8'h11);
    recv_resp(0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h99;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_mid_state: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00",
               req_ready, resp_valid, resp_err, resp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_mid_idle i=%0d: valid=%b ready=%b, required 0 1", i, resp_valid, req_ready);
      end
    end
    send_req(1'b0, 8'h20, 8'h00, 1'b0, 8'h11);
    recv_resp(0);
  endtask

  task automatic test_back_to_back();
    int acc[16];
    int got;
    logic [8:0] exp_v;
    @(negedge clk);
    t_resp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int n;
          t_req_valid = 1'b1;
          t_req_write = (i < 8);
          t_req_addr  = 8'(i % 8);
          t_req_wdata = 8'(i % 8) + 8'h40;
          n = 0;
          while (t_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
          end
          exp_q.push_back({1'b0, 8'(i % 8) + 8'h40});
          @(posedge clk);
          acc[i] = cyc;
          @(negedge clk);
        end
        t_req_valid = 1'b0;
      end
      begin
        got = 0;
        for (int c = 0; c < 300 && got < 16; c++) begin
          @(negedge clk);
          if (t_resp_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
              tests_failed++;
              $display("FAIL b2b_unexpected: rdata=%h with empty scoreboard", t_resp_rdata);
            end else begin
              exp_v = exp_q.pop_front();
              if ({t_resp_err, t_resp_rdata} !== exp_v) begin
                tests_failed++;
                $display("FAIL b2b_data n=%0d: err=%b rdata=%h, required err=%b rdata=%h",
                         got, t_resp_err, t_resp_rdata, exp_v[8], exp_v[7:0]);
              end
            end
            got++;
          end
        end
      end
    join
    t_resp_ready = 1'b0;
    tests_run++;
    if (got != 16) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d responses, required 16", got);
    end
    for (int i = 1; i < 16; i++) begin
      tests_run++;
      if (acc[i] - acc[i-1] != 3) begin
        tests_failed++;
        $display("FAIL b2b_spacing i=%0d: %0d cycles, required 3", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_out_of_range();
    test_reset_mid();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder (slave) end of the CPU's data-memory request/response interface. It accepts one read or write request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs the access on an internal byte-wide array and returns the result over a second valid/ready handshake. It sits between the CPU's memory-access stage and storage, and replaces the zero-latency data array so the CPU's memory stage can be exercised against realistic latency and backpressure.

## Interface
- `ADDR_W`, 8: request address width.
- `DATA_W`, 8: data width.
- `DEPTH`, 256: number of implemented words. Legal range is 1 to 2^ADDR_W.
- `WAIT_CYCLES`, 2: wait states inserted before each access. Legal range is 0 to 15.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: initiator presents a request.
- `req_ready`  out  1: responder can accept a request.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: word address.
- `req_wdata`  in  DATA_W: write data; ignored for reads.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: initiator accepts the response.
- `resp_rdata`  out  DATA_W: read data, or the committed write data for writes.
- `resp_err`  out  1: `req_addr` ≥ DEPTH.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counts wait states.
  - ACCESS: one cycle; performs the array operation.
  - RESP: `resp_valid`=1.
- IDLE: on an edge with `req_valid`=1, capture `req_write`, `req_addr` and `req_wdata` into holding registers.
  - If WAIT_CYCLES>0, go to WAIT with counter = WAIT_CYCLES-1.
  - Otherwise go to ACCESS.
- WAIT: decrement the counter each edge. Go to ACCESS on the edge where the counter is 0.
- ACCESS edge, in-range address (addr < DEPTH):
  - Write: array[addr] ← wdata; `resp_rdata` ← wdata.
  - Read: `resp_rdata` ← array[addr].
  - `resp_err` ← 0. Go to RESP.
- ACCESS edge, out-of-range address:
  - Array is untouched.
  - `resp_rdata` ← 0; `resp_err` ← 1. Go to RESP.
- RESP: `resp_valid`, `resp_rdata` and `resp_err` are held stable until an edge with `resp_ready`=1. That edge completes the transaction and returns the FSM to IDLE.
- Request inputs are sampled only on the accept edge. Changes afterwards have no effect. `req_valid` while `req_ready`=0 is ignored, not queued.
- Array contents are not reset. The array is only modified on a write ACCESS edge.
- Reset:
  - State → IDLE; `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; wait counter=0.
  - Reset has priority over every other event on the same edge.
  - A write aborted by reset before its ACCESS edge is never committed.

## Timing
- Accept edge N = first edge with `req_valid`=1 and `req_ready`=1.
- ACCESS edge = N+1+WAIT_CYCLES. `resp_valid` is first high in the cycle after it.
- Completion edge = the first edge at or after N+2+WAIT_CYCLES with `resp_ready`=1. `req_ready` is high in the following cycle.
- Minimum spacing between accept edges = WAIT_CYCLES+3 cycles, reached with `resp_ready` tied high.
- `req_ready` and `resp_valid` are never high in the same cycle.
- `req_ready`, `resp_valid`, `resp_rdata` and `resp_err` are registered outputs. There are no combinational input-to-output paths.
- Read-after-write to the same address in consecutive transactions returns the new data, because the write commits two or more edges before the next ACCESS.

## Test plan
- Reset behaviour:
  - Stimulus: hold `reset` for 2 cycles with random inputs.
  - Required: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0x00, `resp_err`=0 in the first cycle after release.
- Write then read, WAIT_CYCLES=2:
  - Stimulus: write 0x3C to 0x10 accepted at edge N.
  - Required: `resp_valid` rises after edge N+3 with `resp_rdata`=0x3C and `resp_err`=0.
  - Stimulus: then read 0x10.
  - Required: `resp_rdata`=0x3C.
- Response backpressure:
  - Stimulus: hold `resp_ready`=0 for 5 cycles during a read of 0x10, while toggling `req_valid` and `req_addr`.
  - Required: `resp_valid`=1 with `resp_rdata` stable at 0x3C; `req_ready`=0 throughout; no new request accepted.
  - Stimulus: raise `resp_ready`.
  - Required: `req_ready`=1 one cycle later.
- Out-of-range address, DEPTH=128:
  - Stimulus: write 0x55 to 0x80.
  - Required: `resp_err`=1, `resp_rdata`=0x00.
  - Stimulus: read 0x00 (preloaded 0xA7).
  - Required: 0xA7, `resp_err`=0.
  - Stimulus: read 0xFF.
  - Required: `resp_err`=1, `resp_rdata`=0x00.
- Reset mid-transaction:
  - Stimulus: 0x20 holds 0x11; write 0x99 to 0x20; assert `reset` during WAIT.
  - Required: the FSM returns to IDLE; a subsequent read of 0x20 returns 0x11.
- Back-to-back throughput, WAIT_CYCLES=0:
  - Stimulus: `resp_ready` tied high; `req_valid` continuously high; addresses 0x00..0x07 after writing 0x00..0x07 with data = addr+0x40.
  - Required: one accept every 3 cycles; read data 0x40..0x47 in order.
